// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch controller and its
// branch history table.
package branch_pkg;

  // 2-bit saturating predictor counter; the MSB is the prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  // Redirect sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } br_state_t;

  localparam bht_cnt_t    BHT_RESET_VAL = WNT;
  localparam int unsigned PC_STEP       = 4;

  // Saturating step of one counter towards the observed outcome.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
    bht_cnt_t nxt;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET_VAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Branch history table: counter storage, combinational lookup and a
// one-cycle-delayed saturating update. A lookup of an index with an update
// still pending returns the pre-update value (no bypass).
module bht_array
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_cnt_t         cnt_q [ENTRIES];
  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;
  logic [1:0]       rd_cnt_s;

  // Lookup: prediction is the MSB of the addressed counter.
  always_comb begin
    rd_cnt_s   = cnt_q[rd_idx_i];
    rd_taken_o = rd_cnt_s[1];
  end

  // Capture each resolution, then apply it to the counter on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= BHT_RESET_VAL;
      end
    end else begin
      upd_valid_q <= upd_en_i;
      if (upd_en_i) begin
        upd_idx_q   <= upd_idx_i;
        upd_taken_q <= upd_taken_i;
      end
      if (upd_valid_q) begin
        cnt_q[upd_idx_q] <= bht_next(cnt_q[upd_idx_q], upd_taken_q);
      end
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch controller: resolves conditional branches against the
// carried IF prediction, flushes and redirects fetch on a mispredict, and
// trains the branch history table.
// Optional build macro BRANCH_CTRL_STATS_EN adds branch/mispredict counters.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic            ex_br_taken,
  output logic            ex_stall,
  output logic            flush,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  br_state_t        state_q;
  logic             redir_valid_q;
  logic [XLEN-1:0]  redir_pc_q;
  logic [XLEN-1:0]  correct_pc_d;
  logic             resolve_s;
  logic             mispredict_s;
  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             unused_if_pc_s;

  assign if_idx_s       = if_pc[IDX_W+1:2];
  assign ex_idx_s       = ex_pc[IDX_W+1:2];
  assign unused_if_pc_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Resolution is masked while a redirect is pending so the held EX
  // instruction is counted once; the fall-through add wraps modulo 2^XLEN.
  always_comb begin
    resolve_s    = ex_valid & ex_is_branch & ~ex_stall;
    mispredict_s = resolve_s & (ex_br_taken != ex_pred_taken);
    if (ex_br_taken) begin
      correct_pc_d = ex_target;
    end else begin
      correct_pc_d = ex_pc + XLEN'(PC_STEP);
    end
  end

  // Redirect sequencer: register the correct PC on a mispredict and hold it
  // until fetch accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mispredict_s) begin
            state_q       <= REDIR;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= correct_pc_d;
          end
        end
        REDIR: begin
          if (redir_ready) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          redir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ex_stall    = (state_q == REDIR);
  assign flush       = mispredict_s;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;

  bht_array #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (if_idx_s),
    .rd_taken_o  (if_pred_taken),
    .upd_en_i    (resolve_s),
    .upd_idx_i   (ex_idx_s),
    .upd_taken_i (ex_br_taken)
  );

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      if (resolve_s) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (mispredict_s) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios followed by random
// traffic, compared cycle by cycle against a behavioural model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_pred_taken, ex_br_taken;
  logic [31:0] ex_pc, ex_target;
  logic        ex_stall, flush, redir_valid, redir_ready;
  logic [31:0] redir_pc;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_br_taken   (ex_br_taken),
    .ex_stall      (ex_stall),
    .flush         (flush),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .redir_ready   (redir_ready)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int          m_bht [16];
  bit          m_redir;
  logic [31:0] m_rpc;
  bit          m_upd_v;
  int          m_upd_idx;
  bit          m_upd_t;
  int unsigned m_nbr, m_nmp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_redir = 0; m_rpc = 32'd0; m_upd_v = 0; m_upd_idx = 0; m_upd_t = 0;
    m_nbr = 0; m_nmp = 0;
  endtask

  task automatic set_ex(input bit v, input bit b, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit pt, input bit bt);
    ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pt; ex_br_taken = bt;
  endtask

  // One clock cycle: inputs were set after a falling edge; check, clock, model.
  task automatic tick();
    bit resolve, misp;
    #1;
    resolve = ex_valid && ex_is_branch && !m_redir;
    misp    = resolve && (ex_br_taken != ex_pred_taken);
    chk("flush", {31'd0, flush}, {31'd0, misp});
    chk("ex_stall", {31'd0, ex_stall}, {31'd0, m_redir});
    chk("redir_valid", {31'd0, redir_valid}, {31'd0, m_redir});
    if (m_redir) chk("redir_pc", redir_pc, m_rpc);
    chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, (m_bht[idx_of(if_pc)] >= 2)});
`ifdef BRANCH_CTRL_STATS_EN
    chk("stat_branches", stat_branches, m_nbr);
    chk("stat_mispredicts", stat_mispredicts, m_nmp);
`endif
    @(posedge clk);
    if (m_upd_v) begin
      if (m_upd_t) m_bht[m_upd_idx] = (m_bht[m_upd_idx] == 3) ? 3 : m_bht[m_upd_idx] + 1;
      else         m_bht[m_upd_idx] = (m_bht[m_upd_idx] == 0) ? 0 : m_bht[m_upd_idx] - 1;
    end
    m_upd_v   = resolve;
    m_upd_idx = idx_of(ex_pc);
    m_upd_t   = ex_br_taken;
    if (m_redir) begin
      if (redir_ready) m_redir = 0;
    end else if (misp) begin
      m_redir = 1;
      m_rpc   = ex_br_taken ? ex_target : ex_pc + 32'd4;
    end
    if (resolve) m_nbr++;
    if (misp)    m_nmp++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'd0; redir_ready = 1'b0;
    set_ex(0, 0, 32'd0, 32'd0, 0, 0);
    model_reset();
    #1;
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_ex_stall", {31'd0, ex_stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Predict-correct, not taken
    if_pc = 32'h100;
    set_ex(1, 1, 32'h100, 32'h200, 0, 0); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick();

    // Mispredict taken, ready tied high
    redir_ready = 1'b1;
    set_ex(1, 1, 32'h100, 32'h200, 0, 1); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick(); tick();

    // Mispredict not-taken with back-pressure; EX holds its instruction
    redir_ready = 1'b0;
    set_ex(1, 1, 32'h204, 32'h300, 1, 0); tick();
    repeat (3) tick();
    redir_ready = 1'b1; tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick();

    // Saturation at pc 0x40
    if_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, 1, 32'h40, 32'h80, 1, 1); tick();
    end
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick();

    // Collision: lookup of index 0 while its update is pending
    if_pc = 32'h80;
    set_ex(1, 1, 32'h0, 32'h40, 0, 0); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick();
    set_ex(1, 1, 32'h0, 32'h40, 1, 1); tick();
    set_ex(1, 1, 32'h0, 32'h40, 1, 1); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick();

    // PC wrap on not-taken fall-through
    set_ex(1, 1, 32'hFFFF_FFFC, 32'h10, 1, 0); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick(); tick();

    // Reset while a redirect and a BHT update are both pending
    redir_ready = 1'b0; if_pc = 32'h100;
    set_ex(1, 1, 32'h100, 32'h200, 0, 1); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("mid_rst_ex_stall", {31'd0, ex_stall}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if_pc = i * 4;
      #1 chk("post_rst_bht", {31'd0, if_pred_taken}, 32'd0);
    end
    @(negedge clk);
    if_pc = 32'h100; redir_ready = 1'b1;
    tick(); tick();
    set_ex(1, 1, 32'h140, 32'h180, 0, 0); tick();
    set_ex(1, 1, 32'h144, 32'h180, 0, 1); tick();
    set_ex(0, 0, 32'h0, 32'h0, 0, 0); tick();
`ifdef BRANCH_CTRL_STATS_EN
    chk("stat_br_after2", stat_branches, 32'd2);
    chk("stat_mp_after2", stat_mispredicts, 32'd1);
`endif
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom_range(0, 47) << 2);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pc,
             $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom_range(0, 1));
      if_pc       = $urandom_range(0, 47) << 2;
      redir_ready = $urandom_range(0, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
